// File: rtl/router_slice_flit_rx.sv
// Receive end of the inter-slice flit link: DEPTH-entry FIFO with valid/ready
// delivery to the router core and one credit pulse returned per consumed flit.
module router_slice_flit_rx #(
    parameter int unsigned  DATA_W = 32,
    parameter int unsigned  DEPTH  = 4,
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ivalid,
    input  logic [DATA_W-1:0] idata,
    output logic              credit_out,
    output logic              ovalid,
    output logic [DATA_W-1:0] odata,
    input  logic              oready,
    output logic [CNT_W-1:0]  count,
    output logic              overflow
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              credit_q;
    logic              overflow_q, overflow_d;
    logic              full;
    logic              pop;
    logic              push;
    logic              drop;

    // Handshake decode; a full FIFO still accepts a flit when a pop frees a slot this cycle.
    always_comb begin
        full = (count_q == CNT_W'(DEPTH));
        pop  = ovalid && oready;
        push = ivalid && (!full || pop);
        drop = ivalid && full && !pop;
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q | drop;
        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (pop && !push) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            credit_q   <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            credit_q   <= pop;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately left uninitialised; only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= idata;
        end
    end

    always_comb begin
        ovalid     = (count_q != '0);
        odata      = ovalid ? mem_q[rd_ptr_q] : '0;
        count      = count_q;
        credit_out = credit_q;
        overflow   = overflow_q;
    end

endmodule

// File: tb/tb_router_slice_flit_rx.sv
// Scoreboard bench for router_slice_flit_rx: stimulus queues expected flits,
// a negedge monitor checks delivery order, idle data and credit timing.
module tb_router_slice_flit_rx;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned DEPTH  = 4;
    localparam int unsigned CNT_W  = $clog2(DEPTH + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              ivalid;
    logic [DATA_W-1:0] idata;
    logic              credit_out;
    logic              ovalid;
    logic [DATA_W-1:0] odata;
    logic              oready;
    logic [CNT_W-1:0]  count;
    logic              overflow;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;
    int unsigned credit_cnt = 0;
    int unsigned credit_base;
    logic        prev_pop = 1'b0;
    logic [DATA_W-1:0] exp_q [$];
    logic [DATA_W-1:0] mon_exp;

    router_slice_flit_rx #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .ivalid     (ivalid),
        .idata      (idata),
        .credit_out (credit_out),
        .ovalid     (ovalid),
        .odata      (odata),
        .oready     (oready),
        .count      (count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ovalid"}, 32'(ovalid), 32'd0);
        check({tag, "_odata"}, odata, 32'd0);
        check({tag, "_credit"}, 32'(credit_out), 32'd0);
        check({tag, "_count"}, 32'(count), 32'd0);
        check({tag, "_overflow"}, 32'(overflow), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every accepted flit and checks credit follows each pop.
    always @(negedge clk) begin
        if (!reset) begin
            prev_pop = 1'b0;
        end else begin
            check("credit_timing", 32'(credit_out), 32'(prev_pop));
            if (credit_out) credit_cnt++;
            if (!ovalid) check("odata_when_idle", odata, 32'd0);
            if (ovalid && oready) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_flit: got 0x%0h, required no flit at %0t", odata, $time);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("flit_order", odata, mon_exp);
                end
            end
            prev_pop = ovalid && oready;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset  = 1'b0;
        ivalid = 1'b0;
        idata  = '0;
        oready = 1'b0;

        // Reset held, then idle.
        for (int i = 0; i < 3; i++) begin
            tick();
            check_idle_outputs("in_reset");
        end
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_idle_outputs("post_reset");
        end

        // Single flit.
        ivalid = 1'b1;
        idata  = 32'hA5A5_0001;
        exp_q.push_back(32'hA5A5_0001);
        tick();
        ivalid = 1'b0;
        check("single_ovalid", 32'(ovalid), 32'd1);
        check("single_odata", odata, 32'hA5A5_0001);
        check("single_count", 32'(count), 32'd1);
        oready = 1'b1;
        tick();
        oready = 1'b0;
        check("single_pop_ovalid", 32'(ovalid), 32'd0);
        check("single_pop_odata", odata, 32'd0);
        check("single_credit_hi", 32'(credit_out), 32'd1);
        tick();
        check("single_credit_lo", 32'(credit_out), 32'd0);

        // Fill then drain.
        for (int i = 0; i < 4; i++) begin
            ivalid = 1'b1;
            idata  = 32'h10 + 32'(i);
            exp_q.push_back(32'h10 + 32'(i));
            tick();
        end
        ivalid = 1'b0;
        check("fill_count", 32'(count), 32'd4);
        credit_base = credit_cnt;
        oready = 1'b1;
        repeat (4) tick();
        oready = 1'b0;
        check("drain_count", 32'(count), 32'd0);
        repeat (2) tick();
        check("drain_credits", credit_cnt - credit_base, 32'd4);

        // Streaming across pointer wrap with oready held high.
        credit_base = credit_cnt;
        oready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            ivalid = 1'b1;
            idata  = 32'h100 + 32'(i);
            exp_q.push_back(32'h100 + 32'(i));
            tick();
            check("stream_count", 32'(count), 32'd1);
        end
        ivalid = 1'b0;
        tick();
        check("stream_drained", 32'(count), 32'd0);
        repeat (2) tick();
        oready = 1'b0;
        check("stream_credits", credit_cnt - credit_base, 32'd20);
        check("stream_no_overflow", 32'(overflow), 32'd0);
        check("stream_all_delivered", exp_q.size(), 32'd0);

        // Overflow: fill, push a flit that must be dropped.
        for (int i = 0; i < 4; i++) begin
            ivalid = 1'b1;
            idata  = 32'h20 + 32'(i);
            exp_q.push_back(32'h20 + 32'(i));
            tick();
        end
        check("ovf_full_count", 32'(count), 32'd4);
        idata = 32'hDEAD;
        tick();
        ivalid = 1'b0;
        check("ovf_flag", 32'(overflow), 32'd1);
        check("ovf_count", 32'(count), 32'd4);
        check("ovf_head", odata, 32'h20);
        // Push+pop while full is accepted.
        ivalid = 1'b1;
        idata  = 32'h24;
        oready = 1'b1;
        exp_q.push_back(32'h24);
        tick();
        ivalid = 1'b0;
        oready = 1'b0;
        check("full_pushpop_count", 32'(count), 32'd4);
        check("ovf_sticky", 32'(overflow), 32'd1);
        check("full_pushpop_head", odata, 32'h21);
        oready = 1'b1;
        tick();
        oready = 1'b0;
        check("pre_reset_count", 32'(count), 32'd3);

        // Asynchronous reset with a pop in flight.
        oready = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        check("async_ovalid", 32'(ovalid), 32'd0);
        check("async_odata", odata, 32'd0);
        check("async_credit", 32'(credit_out), 32'd0);
        check("async_count", 32'(count), 32'd0);
        check("async_overflow", 32'(overflow), 32'd0);
        exp_q.delete();
        oready = 1'b0;
        tick();
        tick();
        check_idle_outputs("mid_reset_hold");
        reset = 1'b1;
        tick();
        check_idle_outputs("mid_reset_release");

        // First flit after reset.
        ivalid = 1'b1;
        idata  = 32'h77;
        exp_q.push_back(32'h77);
        tick();
        ivalid = 1'b0;
        check("after_reset_ovalid", 32'(ovalid), 32'd1);
        check("after_reset_odata", odata, 32'h77);
        check("after_reset_count", 32'(count), 32'd1);
        oready = 1'b1;
        tick();
        oready = 1'b0;
        repeat (2) tick();
        check("final_queue_empty", exp_q.size(), 32'd0);
        check("final_count", 32'(count), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
